// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_md_seq.sv
// Mult/div sequencer: tracks an in-flight operation for MD_LAT cycles after md_start.
module hazard_stall_ctrl_md_seq
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MD_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  output logic md_busy,
  output logic in_busy
);

  localparam int unsigned CW = $clog2(MD_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 1);

  md_state_t     state, state_nxt;
  logic [CW-1:0] md_cnt, md_cnt_nxt;
  logic          md_busy_nxt;

  assign in_busy = (state == MD_BUSY);

  // State register; updates on the falling edge to line up with the segment registers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MD_IDLE;
      md_cnt  <= '0;
      md_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      md_cnt  <= md_cnt_nxt;
      md_busy <= md_busy_nxt;
    end
  end

  // Next-state: load the latency count on start, count down (gated at zero) while busy.
  always_comb begin
    state_nxt   = state;
    md_cnt_nxt  = md_cnt;
    md_busy_nxt = md_busy;
    case (state)
      MD_IDLE: begin
        if (md_start) begin
          state_nxt   = MD_BUSY;
          md_cnt_nxt  = CNT_LOAD;
          md_busy_nxt = 1'b1;
        end
      end
      MD_BUSY: begin
        if (md_cnt == '0) begin
          state_nxt   = MD_IDLE;
          md_busy_nxt = 1'b0;
        end else begin
          md_cnt_nxt = md_cnt - CW'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubble, PC/IF-ID stall, branch flush, mult/div issue.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MD_LAT = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             ID_is_md,
  input  logic             ID_rd_hilo,
  input  logic [4:0]       EX_rt,
  input  logic             EX_MemtoReg,
  input  logic             EX_RegWr,
  input  logic             EX_br_taken,
  output logic             Load_use,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic md_in_busy;
  logic lu_haz;
  logic md_haz;

  hazard_stall_ctrl_md_seq #(
    .MD_LAT (MD_LAT)
  ) u_md_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (md_start),
    .md_busy  (md_busy),
    .in_busy  (md_in_busy)
  );

  // Hazard detection: load result needed by ID, or hi/lo/mult-div unit still occupied.
  always_comb begin
    lu_haz = EX_MemtoReg & EX_RegWr & (EX_rt != REG_ZERO) &
             ((ID_use_rs & (ID_rs == EX_rt)) | (ID_use_rt & (ID_rt == EX_rt)));
    md_haz = md_in_busy & (ID_is_md | ID_rd_hilo);
  end

  // Priority resolution: taken branch squashes ID, then hazards stall, then mult/div issue.
  // md_start is also held off while reset is asserted so nothing issues from the reset state.
  always_comb begin
    Load_use    = 1'b0;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    md_start    = 1'b0;
    if (EX_br_taken) begin
      if_id_flush = 1'b1;
      Load_use    = 1'b1;
    end else if (lu_haz | md_haz) begin
      Load_use    = 1'b1;
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
    end else if (!md_in_busy & ID_is_md & rst_n) begin
      md_start = 1'b1;
    end
  end

  // Saturating count of PC-stall cycles.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (pc_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
